packet_generator: RTL and testbench
===================================

// Module: packet_generator
// PURPOSE
//  Parametrised multi-packet traffic source for NoC router benches. Emits PACKETS packets
//  of FLITS flits each over a 2-phase (toggle) req/ack channel into a router local port.
//  Payload comes from an internal LFSR; head flit carries the destination. Adds inter-packet
//  gap, enable gating, packet count and completion status.
// PARAMETERS
//  ID               0  source index, used in log prefix and LFSR seed mixing
//  SIZE             8  flit width in bits; must satisfy SIZE-1 > DESTINATION_BITS
//  DESTINATION_BITS 4  destination field width
//  DESTINATION      0  destination written into every head flit
//  FLITS            8  flits per packet, >=1 (FLITS=1: head only)
//  PACKETS          4  packets to send; 0 = unlimited
//  GAP              0  idle cycles between last ack of a packet and next head flit
//  SEED             1  LFSR seed; seed 0 replaced by 1
//  TIMEOUT        255  ack timeout in cycles (used only with PACKET_GENERATOR_TIMEOUT_EN)
// PORTS
//  clk           in   1     clock, all logic on posedge
//  reset         in   1     synchronous, active-high reset
//  enable        in   1     permit starting a new packet
//  ack           in   1     2-phase ack from sink; each toggle accepts one flit
//  req           out  1     2-phase req; toggles once per flit launched
//  data          out  SIZE  flit, stable from req toggle until its ack
//  busy          out  1     high while a packet is in flight (head launched to last ack)
//  done          out  1     high once PACKETS packets fully acked; never for PACKETS=0
//  packets_sent  out  16    completed packets, wraps at 2^16
//  error         out  1     sticky ack timeout flag
// BEHAVIOUR
//  - Reset (sync): req=0, data=0, busy=0, done=0, error=0, packets_sent=0, ack_old=0,
//    flit_idx=0, gap_cnt=0, LFSR=SEED^ID (nonzero), state=IDLE. Reset mid-packet abandons it.
//  - ack_received = ack ^ ack_old; ack_old <= ack every cycle.
//  - Flit format: [SIZE-1]=1 head / 0 body. Head: {1, lfsr[SIZE-2:DESTINATION_BITS],
//    DESTINATION}. Body: {0, lfsr[SIZE-2:0]}. LFSR: 32-bit Galois, taps 32,22,2,1;
//    advances once per flit launched; flit bits taken before advance.
//  - FSM states IDLE, SEND, WAIT, GAP, DONE:
//    IDLE: enable && !done -> SEND; else stay.
//    SEND (1 cycle): data<=flit, req<=~req, busy<=1, flit_idx++ -> WAIT.
//    WAIT: ack_received: if flit_idx<FLITS -> SEND; else packets_sent++, busy<=0,
//      flit_idx<=0, then DONE if count reached, else GAP if GAP>0, else IDLE.
//    GAP: count GAP cycles -> IDLE.  DONE: done=1, hold; only reset leaves.
//  - Latency: first req toggle at 2nd edge after enable seen high in IDLE; back-to-back
//    flits with immediate ack: one req toggle per 2 cycles.
//  - enable low mid-packet: packet completes; generator holds in IDLE afterwards.
//  - ack toggle in any state other than WAIT: ignored (protocol violation, no state change).
//  - Simultaneous reset and ack toggle: reset wins.
// CONFIGURATION
//  PACKET_GENERATOR_TIMEOUT_EN defined: counter runs in WAIT, cleared per flit; reaching
//   TIMEOUT cycles without ack sets error=1 and moves to DONE (done stays 0).
//  Undefined: WAIT waits forever; error tied 0; no counter logic.
// STRUCTURE
//  - Shared header packet_defs.v: flit head-bit position, header field offsets, FSM state
//    encodings, LFSR tap constant; used also by the packet sink/checker.
//  - Sub-module lfsr32 (clk, reset, seed, step, value): Galois LFSR, one instance.
// TESTING
//  1 FLITS=8,PACKETS=1, sink acks 1 cycle after each req toggle -> 8 req toggles, first
//    flit MSB=1, DESTINATION in low bits, flits 2..8 MSB=0, done=1, packets_sent=1.
//  2 PACKETS=3,GAP=5 -> exactly 5 idle cycles between last ack and next head toggle;
//    packets_sent 1,2,3 then done.
//  3 enable dropped after 2nd flit of packet 1 -> all 8 flits still sent, then no req
//    toggle while enable=0; resumes with packet 2 on enable=1.
//  4 Reset asserted in WAIT of flit 4 -> next cycle req=0,data=0,busy=0,packets_sent=0;
//    restart reproduces identical flit sequence to scenario 1 (same SEED).
//  5 TIMEOUT_EN, TIMEOUT=10, sink never acks -> error=1 at 10th WAIT cycle, done=0, no
//    further req toggles; without macro, req held, error=0 after 1000 cycles.
//  6 Spurious ack toggle during GAP -> ignored, flit count and data unchanged.

Source files
------------

// File: rtl/packet_generator_pkg.sv
// Shared definitions for the packet generator and its sink/checker:
// FSM encoding, LFSR feedback taps and LFSR step/seed helpers.
package packet_generator_pkg;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting towards bit 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int unsigned PACKET_COUNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } gen_state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] value);
    lfsr_next = value[0] ? ({1'b0, value[31:1]} ^ LFSR_TAPS) : {1'b0, value[31:1]};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  function automatic logic [31:0] lfsr_seed(input logic [31:0] seed);
    lfsr_seed = (seed == 32'd0) ? 32'd1 : seed;
  endfunction

endpackage

// File: rtl/packet_generator_lfsr32.sv
// 32-bit Galois LFSR payload source: reloads its seed on reset and
// advances one position per asserted step.
module lfsr32
  import packet_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] state_r;

  // LFSR register: seed on reset, advance on step, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= lfsr_seed(seed);
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign value = state_r;

endmodule

// File: rtl/packet_generator.sv
// Multi-packet NoC traffic source on a 2-phase req/ack channel.
// Optional ack watchdog enabled by defining PACKET_GENERATOR_TIMEOUT_EN.
module packet_generator
  import packet_generator_pkg::*;
#(
  parameter int ID               = 0,
  parameter int SIZE             = 8,
  parameter int DESTINATION_BITS = 4,
  parameter int DESTINATION      = 0,
  parameter int FLITS            = 8,
  parameter int PACKETS          = 4,
  parameter int GAP              = 0,
  parameter int SEED             = 1,
  parameter int TIMEOUT          = 255
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      ack,
  output logic                      req,
  output logic [SIZE-1:0]           data,
  output logic                      busy,
  output logic                      done,
  output logic [PACKET_COUNT_W-1:0] packets_sent,
  output logic                      error
);

  localparam int IDX_W = $clog2(FLITS + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [31:0]                 SEED_MIX  = 32'(SEED) ^ 32'(ID);
  localparam logic [IDX_W-1:0]            FLITS_C   = IDX_W'(FLITS);
  localparam logic [GAP_W-1:0]            GAP_LAST  = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [DESTINATION_BITS-1:0] DEST_C    = DESTINATION_BITS'(DESTINATION);
  localparam logic [PACKET_COUNT_W-1:0]   PACKETS_C = PACKET_COUNT_W'(PACKETS);
  localparam logic                        HAS_GAP   = (GAP > 0);
  localparam logic                        LIMITED   = (PACKETS != 0);

  gen_state_e                  state_r;
  gen_state_e                  state_next_s;
  logic                        ack_old_r;
  logic                        ack_received_s;
  logic [IDX_W-1:0]            flit_idx_r;
  logic [GAP_W-1:0]            gap_cnt_r;
  logic                        req_r;
  logic [SIZE-1:0]             data_r;
  logic                        busy_r;
  logic                        done_r;
  logic [PACKET_COUNT_W-1:0]   packets_sent_r;
  logic [31:0]                 lfsr_value_s;
  logic [SIZE-1:0]             flit_s;
  logic                        more_flits_s;
  logic                        count_reached_s;
  logic                        launch_s;
  logic                        packet_end_s;
  logic                        gap_run_s;
  logic                        timeout_s;
  logic                        unused_s;

  assign ack_received_s  = ack ^ ack_old_r;
  assign more_flits_s    = (flit_idx_r < FLITS_C);
  assign count_reached_s = LIMITED && ((packets_sent_r + 16'd1) == PACKETS_C);

  lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_MIX),
    .step  (launch_s),
    .value (lfsr_value_s)
  );

  // Flit formatter: head carries the destination, body carries LFSR payload
  always_comb begin
    if (flit_idx_r == {IDX_W{1'b0}}) begin
      flit_s = {1'b1, lfsr_value_s[SIZE-2:DESTINATION_BITS], DEST_C};
    end else begin
      flit_s = {1'b0, lfsr_value_s[SIZE-2:0]};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; an ack arriving with the timeout takes priority
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable && !done_r) state_next_s = S_SEND;
        else                   state_next_s = S_IDLE;
      end
      S_SEND: state_next_s = S_WAIT;
      S_WAIT: begin
        if (ack_received_s) begin
          if (more_flits_s)         state_next_s = S_SEND;
          else if (count_reached_s) state_next_s = S_DONE;
          else if (HAS_GAP)         state_next_s = S_GAP;
          else                      state_next_s = S_IDLE;
        end else if (timeout_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) state_next_s = S_IDLE;
        else                       state_next_s = S_GAP;
      end
      S_DONE:  state_next_s = S_DONE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM output decode: per-cycle strobes steering the datapath registers
  always_comb begin
    launch_s     = 1'b0;
    packet_end_s = 1'b0;
    gap_run_s    = 1'b0;
    case (state_r)
      S_SEND: launch_s = 1'b1;
      S_WAIT: begin
        if (ack_received_s && !more_flits_s) packet_end_s = 1'b1;
        else                                 packet_end_s = 1'b0;
      end
      S_GAP:   gap_run_s = 1'b1;
      default: launch_s  = 1'b0;
    endcase
  end

  // Datapath: ack edge detector, flit launch, packet accounting, gap timer
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_old_r      <= 1'b0;
      req_r          <= 1'b0;
      data_r         <= {SIZE{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      packets_sent_r <= {PACKET_COUNT_W{1'b0}};
      flit_idx_r     <= {IDX_W{1'b0}};
      gap_cnt_r      <= {GAP_W{1'b0}};
    end else begin
      ack_old_r <= ack;
      if (launch_s) begin
        data_r     <= flit_s;
        req_r      <= ~req_r;
        busy_r     <= 1'b1;
        flit_idx_r <= flit_idx_r + IDX_W'(1);
      end else if (packet_end_s) begin
        packets_sent_r <= packets_sent_r + 16'd1;
        busy_r         <= 1'b0;
        flit_idx_r     <= {IDX_W{1'b0}};
        if (count_reached_s) done_r <= 1'b1;
      end
      if (gap_run_s) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      else           gap_cnt_r <= {GAP_W{1'b0}};
    end
  end

`ifdef PACKET_GENERATOR_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [TO_W-1:0] timeout_cnt_r;
  logic            error_r;

  assign timeout_s = (state_r == S_WAIT) && !ack_received_s && (timeout_cnt_r == TO_LAST);

  // Ack watchdog: counts WAIT cycles, restarts for every flit, error is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_cnt_r <= {TO_W{1'b0}};
      error_r       <= 1'b0;
    end else begin
      if (state_r == S_WAIT) timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
      else                   timeout_cnt_r <= {TO_W{1'b0}};
      if (timeout_s) error_r <= 1'b1;
      else           error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  // Upper LFSR bits beyond the flit width are intentionally not transmitted
  assign unused_s = ^{lfsr_value_s, 32'(TIMEOUT)};

  assign req          = req_r;
  assign data         = data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign packets_sent = packets_sent_r;

endmodule

// File: tb/tb_packet_generator.sv
// Directed bench for packet_generator: three instances cover single packet,
// gapped multi-packet/enable gating/spurious ack, and the never-acking sink.
module tb_packet_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, enable_a, ack_a, req_a, busy_a, done_a, error_a;
  logic reset_b, enable_b, ack_b, req_b, busy_b, done_b, error_b;
  logic reset_c, enable_c, ack_c, req_c, busy_c, done_c, error_c;
  logic [7:0]  data_a, data_b, data_c;
  logic [15:0] sent_a, sent_b, sent_c;

  packet_generator #(.ID(0), .DESTINATION(5), .FLITS(8), .PACKETS(1), .GAP(0), .SEED(1)) u_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .ack(ack_a), .req(req_a), .data(data_a),
    .busy(busy_a), .done(done_a), .packets_sent(sent_a), .error(error_a));

  packet_generator #(.ID(3), .DESTINATION(9), .FLITS(8), .PACKETS(3), .GAP(5), .SEED(7)) u_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .ack(ack_b), .req(req_b), .data(data_b),
    .busy(busy_b), .done(done_b), .packets_sent(sent_b), .error(error_b));

  packet_generator #(.ID(1), .DESTINATION(2), .FLITS(8), .PACKETS(0), .SEED(1), .TIMEOUT(10)) u_c (
    .clk(clk), .reset(reset_c), .enable(enable_c), .ack(ack_c), .req(req_c), .data(data_c),
    .busy(busy_c), .done(done_c), .packets_sent(sent_c), .error(error_c));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // seed 1: head {1,000,0101}, bodies are the low 7 LFSR bits after each step
  logic [7:0] exp_a [0:7] = '{8'h85, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};

  logic [7:0] flits_a [0:7];
  int tcyc_a [0:7];
  int tog_a, tog_b, tog_c;
  int last_tog_b, prev_tog_b;
  logic prev_req_a, prev_req_b, prev_req_c;
  logic [7:0] head_b, data_c_first;
  logic body_msb_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, log req toggles, act as the ack sinks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (req_a !== prev_req_a) begin
      if (tog_a < 8) begin
        flits_a[tog_a] = data_a;
        tcyc_a[tog_a]  = cyc;
      end
      tog_a++;
      ack_a = ~ack_a;
    end
    prev_req_a = req_a;
    if (req_b !== prev_req_b) begin
      if ((tog_b % 8) == 0) head_b = data_b;
      else body_msb_b = body_msb_b | data_b[7];
      tog_b++;
      prev_tog_b = last_tog_b;
      last_tog_b = cyc;
      ack_b = ~ack_b;
    end
    prev_req_b = req_b;
    if (req_c !== prev_req_c) begin
      if (tog_c == 0) data_c_first = data_c;
      tog_c++;
    end
    prev_req_c = req_c;
  endtask

  initial begin
    int c0;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    enable_a = 1'b0; enable_b = 1'b0; enable_c = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    tog_a = 0; tog_b = 0; tog_c = 0; last_tog_b = 0; prev_tog_b = 0;
    prev_req_a = 1'b0; prev_req_b = 1'b0; prev_req_c = 1'b0;
    head_b = 8'h00; data_c_first = 8'h00; body_msb_b = 1'b0;
    repeat (3) step();

    check("reset_ctrl_a", {req_a, busy_a, done_a, error_a}, 4'b0000);
    check("reset_data_a", data_a, 8'h00);
    check("reset_sent_a", sent_a, 16'd0);
    check("reset_ctrl_b", {req_b, busy_b, done_b, error_b}, 4'b0000);
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    repeat (3) step();
    check("idle_no_start", tog_a + tog_b + tog_c, 0);

    // Single packet with immediate ack
    enable_a = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 60 && !done_a; k++) step();
    check("s1_done", done_a, 1'b1);
    check("s1_toggles", tog_a, 8);
    check("s1_first_latency", tcyc_a[0] - c0, 2);
    check("s1_flit_spacing", tcyc_a[1] - tcyc_a[0], 2);
    check("s1_burst_span", tcyc_a[7] - tcyc_a[0], 14);
    for (int i = 0; i < 8; i++) check($sformatf("s1_flit%0d", i), flits_a[i], exp_a[i]);
    check("s1_sent", sent_a, 16'd1);
    check("s1_busy_after", busy_a, 1'b0);
    repeat (10) step();
    check("s1_hold_in_done", tog_a, 8);

    // Reset in WAIT of flit 4, coinciding with its ack toggle
    reset_a = 1'b1; ack_a = 1'b0;
    step();
    reset_a = 1'b0; tog_a = 0; prev_req_a = req_a;
    for (int k = 0; k < 30 && tog_a < 4; k++) step();
    check("s4_busy_mid", busy_a, 1'b1);
    check("s4_data_flit4", data_a, exp_a[3]);
    reset_a = 1'b1; ack_a = 1'b0;
    step();
    check("s4_reset_ctrl", {req_a, busy_a, done_a}, 3'b000);
    check("s4_reset_data", data_a, 8'h00);
    check("s4_reset_sent", sent_a, 16'd0);
    reset_a = 1'b0; tog_a = 0; prev_req_a = req_a;
    c0 = cyc;
    for (int k = 0; k < 60 && !done_a; k++) step();
    check("s4_restart_latency", tcyc_a[0] - c0, 2);
    for (int i = 0; i < 8; i++) check($sformatf("s4_flit%0d", i), flits_a[i], exp_a[i]);
    check("s4_sent", sent_a, 16'd1);

    // Enable dropped after flit 2 of packet 1
    enable_b = 1'b1;
    for (int k = 0; k < 20 && tog_b < 2; k++) step();
    enable_b = 1'b0;
    for (int k = 0; k < 60 && sent_b != 16'd1; k++) step();
    check("s3_sent1", sent_b, 16'd1);
    check("s3_all_flits", tog_b, 8);
    check("s3_head", {head_b[7], head_b[3:0]}, 5'b1_1001);
    check("s3_body_msb", body_msb_b, 1'b0);

    // Spurious ack toggle while in GAP
    c0 = int'(data_b);
    ack_b = ~ack_b;
    repeat (3) step();
    check("s6_no_toggle", tog_b, 8);
    check("s6_sent", sent_b, 16'd1);
    check("s6_data_held", data_b, c0[7:0]);
    repeat (20) step();
    check("s3_idle_while_disabled", tog_b, 8);
    check("s3_busy_idle", busy_b, 1'b0);

    // Resume: packet 2 then gapped packet 3
    enable_b = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 10 && tog_b < 9; k++) step();
    check("s3_resume_latency", last_tog_b - c0, 2);
    check("s3_head2", {head_b[7], head_b[3:0]}, 5'b1_1001);
    for (int k = 0; k < 60 && sent_b != 16'd2; k++) step();
    check("s2_sent2", sent_b, 16'd2);
    check("s2_done_early", done_b, 1'b0);
    for (int k = 0; k < 20 && tog_b < 17; k++) step();
    check("s2_gap_spacing", last_tog_b - prev_tog_b, 8);
    for (int k = 0; k < 60 && !done_b; k++) step();
    check("s2_done", done_b, 1'b1);
    check("s2_sent3", sent_b, 16'd3);
    check("s2_toggles", tog_b, 24);
    check("s2_body_msb", body_msb_b, 1'b0);
    repeat (10) step();
    check("s2_hold_in_done", tog_b, 24);

    // Sink that never acks; zero effective seed replaced by 1
    enable_c = 1'b1;
    for (int k = 0; k < 10 && tog_c < 1; k++) step();
    check("s5_first_flit", data_c_first, 8'h82);
`ifdef PACKET_GENERATOR_TIMEOUT_EN
    repeat (9) step();
    check("s5_error_before", error_c, 1'b0);
    step();
    check("s5_error_set", error_c, 1'b1);
    check("s5_done_low", done_c, 1'b0);
    repeat (20) step();
    check("s5_no_more_req", tog_c, 1);
`else
    repeat (1000) step();
    check("s5_req_held", tog_c, 1);
    check("s5_error_low", error_c, 1'b0);
    check("s5_busy_held", busy_c, 1'b1);
    check("s5_done_low", done_c, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
